star_ctrl: RTL and testbench

STAR_CTRL -- requirements
Module: star_ctrl

---
 rtl/star_ctrl_pkg.sv | 21 ++
 rtl/star_hit_cmp.sv | 31 +++
 rtl/star_ctrl.sv | 116 +++++++++++
 tb/tb_star_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/star_ctrl_pkg.sv
// star_ctrl shared definitions: slot count, hit box size,
// constant star world positions and the controller state set.
package star_ctrl_pkg;

  localparam int NSLOT = 4;
  localparam int BOX   = 12;

  // Slot world positions, entry i belongs to slot i.
  localparam logic [3:0][9:0] SLOT_X = {
    10'd512, 10'd416, 10'd320, 10'd224
  };
  localparam logic [3:0][9:0] SLOT_Y = {
    10'd140, 10'd180, 10'd160, 10'd180
  };

  typedef enum logic {
    SCAN = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/star_hit_cmp.sv
// Box-overlap test between the character and one star.
// Ports: char_x_i/char_y_i, star_x_i/star_y_i in, hit_o out.
module star_hit_cmp
  import star_ctrl_pkg::*;
#(
  parameter int BOX_P = BOX
) (
  input  logic [9:0] char_x_i,
  input  logic [9:0] char_y_i,
  input  logic [9:0] star_x_i,
  input  logic [9:0] star_y_i,
  output logic       hit_o
);

  localparam logic [10:0] B = 11'(BOX_P);

  logic [10:0] cx;
  logic [10:0] cy;
  logic [10:0] sx;
  logic [10:0] sy;

  // Widened to 11 bits so box edges near 1023 never wrap.
  assign cx = {1'b0, char_x_i};
  assign cy = {1'b0, char_y_i};
  assign sx = {1'b0, star_x_i};
  assign sy = {1'b0, star_y_i};

  assign hit_o = (cx + B >= sx) && (cx <= sx + B)
              && (cy + B >= sy) && (cy <= sy + B);

endmodule

// File: rtl/star_ctrl.sv
// Star collection controller: scans one slot per cycle
// through a shared hit comparator, counts collected stars.
// Ports: sys_clk, RST, char_X/char_Y, bg_pos, level_start,
// freeze, rd_idx in; rd_x/rd_y/rd_en, star_en,
// collect_pulse/collect_idx, star_count, all_done out.
module star_ctrl
  import star_ctrl_pkg::*;
#(
  parameter int NSLOT = star_ctrl_pkg::NSLOT,
  parameter int BOX   = star_ctrl_pkg::BOX
) (
  input  logic             sys_clk,
  input  logic             RST,
  input  logic [9:0]       char_X,
  input  logic [9:0]       char_Y,
  input  logic [9:0]       bg_pos,
  input  logic             level_start,
  input  logic             freeze,
  input  logic [1:0]       rd_idx,
  output logic [9:0]       rd_x,
  output logic [9:0]       rd_y,
  output logic             rd_en,
  output logic [NSLOT-1:0] star_en,
  output logic             collect_pulse,
  output logic [1:0]       collect_idx,
  output logic [3:0]       star_count,
  output logic             all_done
);

  localparam logic [NSLOT-1:0] ALL_ON = {NSLOT{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [NSLOT-1:0] en_q, en_d;
  logic             pulse_q, pulse_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             hit;
  logic [NSLOT-1:0] en_clr;
  logic             scan_go;

  star_hit_cmp #(
    .BOX_P (BOX)
  ) u_cmp (
    .char_x_i (char_X),
    .char_y_i (char_Y),
    .star_x_i (SLOT_X[ptr_q]),
    .star_y_i (SLOT_Y[ptr_q]),
    .hit_o    (hit)
  );

  assign en_clr  = en_q & ~(NSLOT'(1) << ptr_q);
  assign scan_go = !level_start && !freeze
                && (state_q == SCAN);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    en_d    = en_q;
    pulse_d = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      level_start: begin
        // Re-arm wins over any hit seen this cycle.
        state_d = SCAN;
        ptr_d   = 2'd0;
        en_d    = ALL_ON;
      end
      scan_go: begin
        ptr_d = ptr_q + 2'd1;
        if (en_q[ptr_q] && hit) begin
          en_d    = en_clr;
          pulse_d = 1'b1;
          idx_d   = ptr_q;
          if (cnt_q != 4'hF)
            cnt_d = cnt_q + 4'd1;
          if (en_clr == '0)
            state_d = DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      state_q <= SCAN;
      ptr_q   <= 2'd0;
      en_q    <= ALL_ON;
      pulse_q <= 1'b0;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      pulse_q <= pulse_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign star_en       = en_q;
  assign collect_pulse = pulse_q;
  assign collect_idx   = idx_q;
  assign star_count    = cnt_q;
  assign all_done      = (state_q == DONE);

  // Screen X wraps modulo 1024 by 10-bit truncation.
  assign rd_x  = SLOT_X[rd_idx] - bg_pos;
  assign rd_y  = SLOT_Y[rd_idx];
  assign rd_en = en_q[rd_idx];

endmodule

// File: tb/tb_star_ctrl.sv
// Randomised scoreboard bench for star_ctrl against a
// behavioural slot-collection model.
module tb_star_ctrl;

  localparam int BOXW = 12;

  logic       sys_clk = 1'b0;
  logic       RST = 1'b0;
  logic [9:0] char_X = '0;
  logic [9:0] char_Y = '0;
  logic [9:0] bg_pos = '0;
  logic       level_start = 1'b0;
  logic       freeze = 1'b0;
  logic [1:0] rd_idx = '0;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic       rd_en;
  logic [3:0] star_en;
  logic       collect_pulse;
  logic [1:0] collect_idx;
  logic [3:0] star_count;
  logic       all_done;

  star_ctrl dut (
    .sys_clk       (sys_clk),
    .RST           (RST),
    .char_X        (char_X),
    .char_Y        (char_Y),
    .bg_pos        (bg_pos),
    .level_start   (level_start),
    .freeze        (freeze),
    .rd_idx        (rd_idx),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_en         (rd_en),
    .star_en       (star_en),
    .collect_pulse (collect_pulse),
    .collect_idx   (collect_idx),
    .star_count    (star_count),
    .all_done      (all_done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  int sx [4] = '{224, 320, 416, 512};
  int sy [4] = '{180, 160, 180, 140};

  // Model state: scan position, armed slots, count.
  int       m_ptr;
  bit [3:0] m_en;
  int       m_cnt;
  bit       m_done;
  int       tot;

  typedef struct {
    int       cyc;
    bit       pulse;
    int       idx;
    bit [3:0] en;
    int       cnt;
    bit       done;
  } exp_t;

  exp_t st_q [$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit overlap(int s, int cx, int cy);
    return (cx + BOXW >= sx[s]) && (cx <= sx[s] + BOXW)
        && (cy + BOXW >= sy[s]) && (cy <= sy[s] + BOXW);
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_en   = 4'hF;
    m_cnt  = 0;
    m_done = 0;
    tot    = 0;
  endtask

  // Drive one cycle and predict the result of the next edge.
  task automatic step(input bit li, input bit fr,
                      input int cx, input int cy);
    exp_t e;
    int   p;
    level_start = li;
    freeze      = fr;
    char_X      = 10'(cx);
    char_Y      = 10'(cy);
    e.pulse = 0;
    e.idx   = 0;
    if (li) begin
      m_en   = 4'hF;
      m_ptr  = 0;
      m_done = 0;
    end else if (!m_done && !fr) begin
      p     = m_ptr;
      m_ptr = (m_ptr + 1) % 4;
      if (m_en[p] && overlap(p, cx, cy)) begin
        m_en[p] = 1'b0;
        e.pulse = 1;
        e.idx   = p;
        tot++;
        if (m_cnt < 15) m_cnt++;
        if (m_en == 4'h0) m_done = 1;
      end
    end
    e.cyc  = cyc + 1;
    e.en   = m_en;
    e.cnt  = m_cnt;
    e.done = m_done;
    st_q.push_back(e);
    @(posedge sys_clk);
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    st_q.delete();
    model_reset();
    repeat (2) @(posedge sys_clk);
    #2;
    RST = 1'b0;
  endtask

  task automatic rd_check(input int bg, input int i);
    int ex;
    bg_pos = 10'(bg);
    rd_idx = 2'(i);
    #1;
    ex = ((sx[i] - bg) % 1024 + 1024) % 1024;
    chk("rd_x", int'(rd_x), ex);
    chk("rd_y", int'(rd_y), sy[i]);
    chk("rd_en", int'(rd_en), int'(m_en[i]));
  endtask

  // Monitor: compares DUT outputs after each edge.
  always @(negedge sys_clk) begin
    exp_t e;
    if (RST) begin
      chk("rst_en", int'(star_en), 15);
      chk("rst_pulse", int'(collect_pulse), 0);
      chk("rst_idx", int'(collect_idx), 0);
      chk("rst_cnt", int'(star_count), 0);
      chk("rst_done", int'(all_done), 0);
    end else if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
      e = st_q.pop_front();
      chk("pulse", int'(collect_pulse), int'(e.pulse));
      if (e.pulse)
        chk("collect_idx", int'(collect_idx), e.idx);
      chk("star_en", int'(star_en), int'(e.en));
      chk("star_count", int'(star_count), e.cnt);
      chk("all_done", int'(all_done), int'(e.done));
    end
  end

  initial begin
    int s, cx, cy;
    bit li, fr;
    model_reset();
    #1;
    RST = 1'b1;
    repeat (3) @(posedge sys_clk);
    #2;
    RST = 1'b0;

    repeat (20) step(0, 0, 0, 0);
    chk("idle_en", int'(star_en), 15);
    chk("idle_cnt", int'(star_count), 0);

    repeat (24) step(0, 0, 224, 180);
    chk("s0_en", int'(star_en), 4'b1110);
    chk("s0_cnt", int'(star_count), 1);

    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 211, 168);
    chk("edge_miss_en", int'(star_en), 15);
    repeat (8) step(0, 0, 212, 168);
    chk("edge_hit_en", int'(star_en), 4'b1110);
    chk("edge_hit_cnt", int'(star_count), 2);

    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      repeat (8) step(0, 0, sx[i], sy[i]);
    chk("all_done", int'(all_done), 1);
    chk("all_en", int'(star_en), 0);
    chk("all_cnt", int'(star_count), 6);
    repeat (8) step(0, 0, sx[3], sy[3]);
    step(1, 1, 0, 0);
    chk("rearm_en", int'(star_en), 15);
    chk("rearm_done", int'(all_done), 0);
    chk("rearm_cnt", int'(star_count), 6);

    repeat (10) step(0, 1, 320, 160);
    chk("frz_cnt", int'(star_count), 6);
    repeat (6) step(0, 0, 320, 160);
    chk("unfrz_cnt", int'(star_count), 7);
    chk("unfrz_en", int'(star_en), 4'b1101);

    for (int i = 0; i < 8 && m_ptr != 2; i++)
      step(0, 0, 0, 0);
    step(1, 0, 416, 180);
    chk("li_hit_en", int'(star_en), 15);
    chk("li_hit_cnt", int'(star_count), 7);

    for (int i = 0; i < 4; i++) rd_check(300, i);
    rd_check(0, 1);
    rd_check(1023, 3);

    repeat (400) begin
      s  = $urandom_range(3);
      cx = sx[s] + $urandom_range(32) - 16;
      cy = sy[s] + $urandom_range(32) - 16;
      li = ($urandom_range(19) == 0);
      fr = ($urandom_range(7) == 0);
      step(li, fr, cx, cy);
      rd_check($urandom_range(1023), $urandom_range(3));
    end
    chk("sat_cnt", int'(star_count), (tot > 15) ? 15 : tot);

    step(1, 0, 0, 0);
    for (int i = 0; i < 8 && m_ptr != 1; i++)
      step(0, 0, 0, 0);
    char_X = 10'd320;
    char_Y = 10'd160;
    do_reset();
    repeat (10) step(0, 0, 0, 0);
    chk("abort_cnt", int'(star_count), 0);
    chk("abort_en", int'(star_en), 15);

    @(negedge sys_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
